// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI bus arbiter: FSM state encodings and
// the values the card-side bus rests at when nobody owns it.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN0  = 2'b01,
    OWN1  = 2'b10,
    GUARD = 2'b11
  } arb_state_t;

  localparam logic BUS_IDLE_SCK  = 1'b0;
  localparam logic BUS_IDLE_MOSI = 1'b1;
  localparam logic BUS_IDLE_CS_N = 1'b1;
  localparam logic BUS_IDLE_MISO = 1'b1;

endpackage

// File: rtl/sd_spi_arb_timer.sv
// Guard-period down-counter plus, when SD_SPI_ARB_TIMEOUT_EN is defined, the
// owner-inactivity watchdog that watches the owner's sck/cs_n for activity.
module sd_spi_arb_timer
  import sd_spi_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic clk_peripheral,
  input  logic reset_n,
  input  logic guard_load,
  output logic guard_done
`ifdef SD_SPI_ARB_TIMEOUT_EN
  ,
  input  logic wd_active,
  input  logic sck,
  input  logic cs_n,
  output logic wd_hit
`endif
);

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_RELOAD = GW'(GUARD_CYCLES - 1);

  logic [GW-1:0] guard_cnt;

  // Loaded on the edge into GUARD; GUARD is left once it has counted down to 0.
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt <= '0;
    end else if (guard_load) begin
      guard_cnt <= GUARD_RELOAD;
    end else if (guard_cnt != '0) begin
      guard_cnt <= guard_cnt - 1'b1;
    end
  end

  assign guard_done = (guard_cnt == '0);

`ifdef SD_SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  logic [TIMEOUT_BITS-1:0] wd_next;
  logic                    armed;
  logic                    prev_sck;
  logic                    prev_cs_n;
  logic                    changed;

  // The first owned cycle only captures a baseline; activity is judged after.
  always_comb begin
    changed = armed && ((sck != prev_sck) || (cs_n != prev_cs_n));
    wd_next = changed ? '0 : wd_cnt + 1'b1;
    wd_hit  = wd_active && (wd_next == '1);
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      armed     <= 1'b0;
      prev_sck  <= BUS_IDLE_SCK;
      prev_cs_n <= BUS_IDLE_CS_N;
    end else begin
      prev_sck  <= sck;
      prev_cs_n <= cs_n;
      if (wd_active) begin
        wd_cnt <= wd_next;
        armed  <= 1'b1;
      end else begin
        wd_cnt <= '0;
        armed  <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/sd_spi_arbiter.sv
// Two-master arbiter for a shared SD-card SPI bus with round-robin ties and a
// deselect guard between owners. Define SD_SPI_ARB_TIMEOUT_EN for the watchdog.
module sd_spi_arbiter
  import sd_spi_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic clk_peripheral,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic sck0,
  input  logic sck1,
  input  logic mosi0,
  input  logic mosi1,
  input  logic cs0_n,
  input  logic cs1_n,
  output logic miso0,
  output logic miso1,
  output logic spi_sck,
  output logic spi_mosi,
  output logic spi_cs_n,
  input  logic spi_miso,
  output logic busy,
  output logic timeout
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       guard_load;
  logic       guard_done;
  logic       own_req;
`ifdef SD_SPI_ARB_TIMEOUT_EN
  logic       wd_hit;
  logic       wd_fire;
  logic       timeout_q;
`endif

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    guard_load = 1'b0;
    own_req    = (state_q == OWN1) ? req1 : req0;
`ifdef SD_SPI_ARB_TIMEOUT_EN
    wd_fire    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        // A request drop wins over a coincident watchdog expiry.
        if (!own_req) begin
          state_d    = GUARD;
          last_d     = (state_q == OWN1);
          guard_load = 1'b1;
        end
`ifdef SD_SPI_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          state_d    = GUARD;
          last_d     = (state_q == OWN1);
          guard_load = 1'b1;
          wd_fire    = 1'b1;
        end
`endif
      end
      GUARD: begin
        if (guard_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_sck  = BUS_IDLE_SCK;
    spi_mosi = BUS_IDLE_MOSI;
    spi_cs_n = BUS_IDLE_CS_N;
    miso0    = BUS_IDLE_MISO;
    miso1    = BUS_IDLE_MISO;
    case (state_q)
      OWN0: begin
        spi_sck  = sck0;
        spi_mosi = mosi0;
        spi_cs_n = cs0_n;
        miso0    = spi_miso;
      end
      OWN1: begin
        spi_sck  = sck1;
        spi_mosi = mosi1;
        spi_cs_n = cs1_n;
        miso1    = spi_miso;
      end
      default: ;
    endcase
  end

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign busy = (state_q != IDLE);

  sd_spi_arb_timer #(
    .GUARD_CYCLES (GUARD_CYCLES),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_timer (
    .clk_peripheral (clk_peripheral),
    .reset_n        (reset_n),
    .guard_load     (guard_load),
    .guard_done     (guard_done)
`ifdef SD_SPI_ARB_TIMEOUT_EN
    ,
    .wd_active      (gnt0 || gnt1),
    .sck            (spi_sck),
    .cs_n           (spi_cs_n),
    .wd_hit         (wd_hit)
`endif
  );

`ifdef SD_SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scoreboard bench for sd_spi_arbiter: a driver applies directed and random
// stimulus and queues the reference model's expected outputs; a monitor checks.
module tb_sd_spi_arbiter;

  localparam int G      = 4;
  localparam int TB     = 8;
  localparam int WD_MAX = (1 << TB) - 1;
`ifdef SD_SPI_ARB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk_peripheral = 1'b0;
  logic reset_n, req0, req1, gnt0, gnt1;
  logic sck0, sck1, mosi0, mosi1, cs0_n, cs1_n, miso0, miso1;
  logic spi_sck, spi_mosi, spi_cs_n, spi_miso, busy, timeout;

  always #5 clk_peripheral = ~clk_peripheral;

  sd_spi_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_BITS(TB)) dut (
    .clk_peripheral (clk_peripheral),
    .reset_n        (reset_n),
    .req0           (req0),
    .req1           (req1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .sck0           (sck0),
    .sck1           (sck1),
    .mosi0          (mosi0),
    .mosi1          (mosi1),
    .cs0_n          (cs0_n),
    .cs1_n          (cs1_n),
    .miso0          (miso0),
    .miso1          (miso1),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
    .spi_cs_n       (spi_cs_n),
    .spi_miso       (spi_miso),
    .busy           (busy),
    .timeout        (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [8:0] exp_q[$];
  int         cyc_q[$];
  event       sample_ev;

  // next-cycle stimulus
  logic nx_rst, nx_r0, nx_r1, nx_s0, nx_m0, nx_c0, nx_s1, nx_m1, nx_c1, nx_mi;

  // reference model: who owns the bus, how much guard time is left, who was served last
  int   owner;
  int   guard_left;
  int   last;
  int   quiet;
  bit   first_own;
  bit   tpulse;
  logic psck, pcs;

  task automatic model_reset();
    owner = -1; guard_left = 0; last = 1; quiet = 0;
    first_own = 1'b0; tpulse = 1'b0; psck = 1'b0; pcs = 1'b1;
  endtask

  function automatic logic [8:0] model_outputs();
    logic g0, g1, bz, to, sk, mo, cs, mi0, mi1;
    g0 = 0; g1 = 0; bz = 0; to = 0; sk = 0; mo = 1; cs = 1; mi0 = 1; mi1 = 1;
    if (nx_rst) begin
      bz = (owner >= 0) || (guard_left > 0);
      to = tpulse;
      if (owner == 0) begin
        g0 = 1; sk = nx_s0; mo = nx_m0; cs = nx_c0; mi0 = nx_mi;
      end else if (owner == 1) begin
        g1 = 1; sk = nx_s1; mo = nx_m1; cs = nx_c1; mi1 = nx_mi;
      end
    end
    return {g0, g1, bz, to, sk, mo, cs, mi0, mi1};
  endfunction

  task automatic model_advance();
    logic s, c, rq;
    bit   tp_n;
    if (!nx_rst) begin
      model_reset();
      return;
    end
    tp_n = 1'b0;
    if (owner >= 0) begin
      s  = (owner == 1) ? nx_s1 : nx_s0;
      c  = (owner == 1) ? nx_c1 : nx_c0;
      rq = (owner == 1) ? nx_r1 : nx_r0;
      if (first_own) quiet = 1;
      else if (s != psck || c != pcs) quiet = 0;
      else quiet++;
      first_own = 1'b0;
      psck = s; pcs = c;
      if (!rq) begin
        last = owner; owner = -1; guard_left = G;
      end else if (WD_EN && quiet == WD_MAX) begin
        last = owner; owner = -1; guard_left = G; tp_n = 1'b1;
      end
    end else if (guard_left > 0) begin
      guard_left--;
    end else begin
      if (nx_r0 && nx_r1) owner = (last == 1) ? 0 : 1;
      else if (nx_r0) owner = 0;
      else if (nx_r1) owner = 1;
      if (owner >= 0) begin
        first_own = 1'b1; quiet = 0;
      end
    end
    tpulse = tp_n;
  endtask

  task automatic tick();
    @(negedge clk_peripheral);
    reset_n = nx_rst; req0 = nx_r0; req1 = nx_r1;
    sck0 = nx_s0; mosi0 = nx_m0; cs0_n = nx_c0;
    sck1 = nx_s1; mosi1 = nx_m1; cs1_n = nx_c1;
    spi_miso = nx_mi;
    exp_q.push_back(model_outputs());
    cyc_q.push_back(cyc);
    -> sample_ev;
    model_advance();
    cyc++;
  endtask

  task automatic rand_lines();
    nx_s0 = 1'($urandom_range(0, 1)); nx_m0 = 1'($urandom_range(0, 1));
    nx_s1 = 1'($urandom_range(0, 1)); nx_m1 = 1'($urandom_range(0, 1));
    nx_mi = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) nx_c0 = ~nx_c0;
    if ($urandom_range(0, 15) == 0) nx_c1 = ~nx_c1;
  endtask

  task automatic run(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) begin
      nx_r0 = r0; nx_r1 = r1;
      rand_lines();
      tick();
    end
  endtask

  // monitor: every presented cycle is checked against the head of the queue
  initial begin
    logic [8:0] got, want;
    int         c;
    forever begin
      @(sample_ev);
      #2;
      got = {gnt0, gnt1, busy, timeout, spi_sck, spi_mosi, spi_cs_n, miso0, miso1};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got %b with no expected entry", got);
      end else begin
        want = exp_q.pop_front();
        c    = cyc_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b required %b (gnt0 gnt1 busy timeout sck mosi cs_n miso0 miso1)",
                   c, got, want);
        end
      end
    end
  end

  initial begin
    model_reset();
    nx_rst = 0; nx_r0 = 0; nx_r1 = 0;
    nx_s0 = 0; nx_m0 = 1; nx_c0 = 1; nx_s1 = 0; nx_m1 = 1; nx_c1 = 1; nx_mi = 0;
    reset_n = 0; req0 = 0; req1 = 0; sck0 = 0; mosi0 = 1; cs0_n = 1;
    sck1 = 0; mosi1 = 1; cs1_n = 1; spi_miso = 0;

    // reset state
    run(3, 0, 0);
    nx_rst = 1;

    // single owner 0, other requester's lines toggling
    nx_c0 = 0; nx_c1 = 0;
    run(12, 1, 0);
    run(8, 0, 0);

    // tie from reset, hand-over through guard, repeat tie
    run(10, 1, 1);
    run(14, 0, 1);
    run(8, 0, 0);
    run(6, 1, 1);
    run(8, 0, 0);

    // short req1 pulse inside the guard window is lost
    run(6, 1, 0);
    run(1, 0, 0);
    run(2, 0, 1);
    run(8, 0, 0);

    // owner 0 silent: watchdog expiry or indefinite hold, build dependent
    for (int i = 0; i < 300; i++) begin
      nx_r0 = 1; nx_r1 = 0; nx_s0 = 0; nx_c0 = 0;
      nx_s1 = 1'($urandom_range(0, 1)); nx_mi = 1'($urandom_range(0, 1));
      tick();
    end
    run(8, 0, 0);

    // reset mid-transfer while owner 1 has cs low, then tie
    nx_c1 = 0;
    run(6, 0, 1);
    nx_rst = 0;
    run(2, 0, 1);
    nx_rst = 1;
    run(5, 1, 1);
    run(8, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) nx_r0 = ~nx_r0;
      if ($urandom_range(0, 7) == 0) nx_r1 = ~nx_r1;
      nx_rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) != 0) rand_lines();
      tick();
    end

    @(negedge clk_peripheral);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
